// File: rtl/multi_key_debouncer_pkg.sv
// multi_key_debouncer_pkg
//   Shared helpers for the multi-key debouncer. They convert a time in ns or us
//   into a clock-cycle count at a given clock frequency in MHz. The result is
//   clamped to at least one cycle.
package multi_key_debouncer_pkg;

    function automatic int unsigned cycles_from_ns(input int unsigned freq_mhz,
                                                   input int unsigned t_ns);
        int unsigned c;
        c = (freq_mhz * t_ns) / 1000;
        return (c == 0) ? 1 : c;
    endfunction

    function automatic int unsigned cycles_from_us(input int unsigned freq_mhz,
                                                   input int unsigned t_us);
        int unsigned c;
        c = freq_mhz * t_us;
        return (c == 0) ? 1 : c;
    endfunction

endpackage

// File: rtl/multi_key_debouncer_channel.sv
// key_debounce_channel
//   Debouncer for a single key: two-flop synchroniser, glitch filter, hold
//   counter, and press / release / long-press strobes. All outputs are
//   registered.
// Ports:
//   clk_i          design clock
//   srst_n_i       synchronous reset, active-low
//   key_i          raw asynchronous key level
//   key_state_o    debounced pressed level (1 = pressed)
//   press_stb_o    one-cycle strobe on an accepted press
//   release_stb_o  one-cycle strobe on an accepted release
//   long_stb_o     one-cycle strobe once a press has lasted L_CYC cycles
module key_debounce_channel #(
    parameter int unsigned G_CYC          = 4,
    parameter int unsigned L_CYC          = 100,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic srst_n_i,
    input  logic key_i,
    output logic key_state_o,
    output logic press_stb_o,
    output logic release_stb_o,
    output logic long_stb_o
);

    localparam int unsigned GW = $clog2(G_CYC + 1);
    localparam int unsigned LW = $clog2(L_CYC + 1);
    localparam logic [GW-1:0] G_LAST = GW'(G_CYC - 1);
    localparam logic [LW-1:0] L_LAST = LW'(L_CYC - 1);
    localparam logic [LW-1:0] L_SAT  = LW'(L_CYC);
    // The synchroniser resets to the released level, so an idle key produces
    // no spurious press when reset is released.
    localparam logic IDLE_LVL = KEY_ACTIVE_LOW;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_state;
    logic [GW-1:0] r_gcnt;
    logic [LW-1:0] r_hcnt;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          w_p;

    assign w_p = r_sync2 ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_sync1   <= IDLE_LVL;
            r_sync2   <= IDLE_LVL;
            r_state   <= 1'b0;
            r_gcnt    <= '0;
            r_hcnt    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_sync1   <= key_i;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            // Any bounce back to the current state restarts the count.
            if (w_p == r_state) begin
                r_gcnt <= '0;
            end else if (r_gcnt == G_LAST) begin
                r_state   <= w_p;
                r_gcnt    <= '0;
                r_press   <= w_p;
                r_release <= ~w_p;
            end else begin
                r_gcnt <= r_gcnt + GW'(1);
            end

            // The hold count parks at L_CYC after firing, so the strobe is one-shot.
            if (!r_state) begin
                r_hcnt <= '0;
            end else if (r_hcnt == L_LAST) begin
                r_hcnt <= L_SAT;
                r_long <= 1'b1;
            end else if (r_hcnt != L_SAT) begin
                r_hcnt <= r_hcnt + LW'(1);
            end
        end
    end

    assign key_state_o   = r_state;
    assign press_stb_o   = r_press;
    assign release_stb_o = r_release;
    assign long_stb_o    = r_long;

endmodule

// File: rtl/multi_key_debouncer.sv
// multi_key_debouncer
//   Debounces N_CHANNELS independent keys in a single clock domain. This top
//   level derives the glitch and long-press cycle counts once. It then
//   instantiates one key_debounce_channel per key.
// Ports:
//   clk_i          design clock
//   srst_n_i       synchronous reset, active-low
//   key_i          raw asynchronous key inputs
//   key_state_o    debounced pressed levels (1 = pressed)
//   press_stb_o    one-cycle strobes on accepted presses
//   release_stb_o  one-cycle strobes on accepted releases
//   long_stb_o     one-cycle strobes when a press reaches LONG_PRESS_US
module multi_key_debouncer
    import multi_key_debouncer_pkg::*;
#(
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned CLK_FREQ_MHZ   = 200,
    parameter int unsigned GLITCH_TIME_NS = 20,
    parameter int unsigned LONG_PRESS_US  = 500000,
    parameter int unsigned KEY_ACTIVE_LOW = 1
) (
    input  logic                  clk_i,
    input  logic                  srst_n_i,
    input  logic [N_CHANNELS-1:0] key_i,
    output logic [N_CHANNELS-1:0] key_state_o,
    output logic [N_CHANNELS-1:0] press_stb_o,
    output logic [N_CHANNELS-1:0] release_stb_o,
    output logic [N_CHANNELS-1:0] long_stb_o
);

    localparam int unsigned G_CYC = cycles_from_ns(CLK_FREQ_MHZ, GLITCH_TIME_NS);
    localparam int unsigned L_CYC = cycles_from_us(CLK_FREQ_MHZ, LONG_PRESS_US);

    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
        key_debounce_channel #(
            .G_CYC          (G_CYC),
            .L_CYC          (L_CYC),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW != 0)
        ) u_ch (
            .clk_i         (clk_i),
            .srst_n_i      (srst_n_i),
            .key_i         (key_i[gi]),
            .key_state_o   (key_state_o[gi]),
            .press_stb_o   (press_stb_o[gi]),
            .release_stb_o (release_stb_o[gi]),
            .long_stb_o    (long_stb_o[gi])
        );
    end

endmodule
